// File: rtl/uart_cmd_rx.sv
// Receive end of the host UART command link: 8N1 deserialiser feeding a
// SETUP-frame parser (opcode, 4-byte address, 4-byte length, MSB first).
module uart_cmd_rx #(
  parameter int         CLK_PER_BIT = 352,
  parameter logic [7:0] OP_SETUP    = 8'h30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rxd,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_opcode,
  output logic [31:0] cmd_addr,
  output logic [31:0] cmd_len,
  output logic [7:0]  rx_byte,
  output logic        rx_byte_valid,
  output logic        frame_error,
  output logic        cmd_error,
  output logic        busy
);

  // state    | meaning
  // B_IDLE   | line idle, waiting for a start edge (armed once line seen high)
  // B_START  | counting to mid start bit, rejects glitches
  // B_DATA   | sampling 8 data bits LSB first at mid-bit
  // B_STOP   | sampling stop bit, publishes byte or flags frame error
  // P_OP     | waiting for an opcode byte
  // P_ADDR   | shifting in 4 address bytes
  // P_LEN    | shifting in 4 length bytes
  // P_HOLD   | command presented, waiting for cmd_ready
  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
  typedef enum logic [1:0] {P_OP, P_ADDR, P_LEN, P_HOLD} parse_state_t;

  localparam logic [8:0] LP_FULL = 9'(CLK_PER_BIT - 1);
  localparam logic [8:0] LP_HALF = 9'(CLK_PER_BIT / 2 - 1);

  logic         r_sync1;
  logic         r_sync2;
  logic         w_rxs;

  bit_state_t   r_bstate;
  logic [8:0]   r_baud;
  logic [2:0]   r_bit_idx;
  logic [7:0]   r_shift;
  logic         r_armed;
  logic [7:0]   r_rx_byte;
  logic         r_rx_byte_valid;
  logic         r_frame_error;

  parse_state_t r_pstate;
  logic [1:0]   r_byte_cnt;
  logic [7:0]   r_cmd_opcode;
  logic [31:0]  r_cmd_addr;
  logic [31:0]  r_cmd_len;
  logic         r_cmd_valid;
  logic         r_cmd_error;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;

  // r_armed forces the line to be seen idle after reset or a bad stop bit,
  // so a start is never detected in the middle of someone else's byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bstate        <= B_IDLE;
      r_baud          <= '0;
      r_bit_idx       <= '0;
      r_shift         <= '0;
      r_armed         <= 1'b0;
      r_rx_byte       <= '0;
      r_rx_byte_valid <= 1'b0;
      r_frame_error   <= 1'b0;
    end else begin
      r_rx_byte_valid <= 1'b0;
      r_frame_error   <= 1'b0;
      case (r_bstate)
        B_IDLE: begin
          if (w_rxs) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_baud   <= LP_HALF;
            r_bstate <= B_START;
          end
        end
        B_START: begin
          if (r_baud == 9'd0) begin
            if (w_rxs) begin
              r_bstate <= B_IDLE;
            end else begin
              r_baud    <= LP_FULL;
              r_bit_idx <= 3'd0;
              r_bstate  <= B_DATA;
            end
          end else begin
            r_baud <= r_baud - 9'd1;
          end
        end
        B_DATA: begin
          if (r_baud == 9'd0) begin
            r_shift[r_bit_idx] <= w_rxs;
            r_baud             <= LP_FULL;
            if (r_bit_idx == 3'd7) begin
              r_bstate <= B_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_baud <= r_baud - 9'd1;
          end
        end
        B_STOP: begin
          if (r_baud == 9'd0) begin
            if (w_rxs) begin
              r_rx_byte       <= r_shift;
              r_rx_byte_valid <= 1'b1;
            end else begin
              r_frame_error <= 1'b1;
              r_armed       <= 1'b0;
            end
            r_bstate <= B_IDLE;
          end else begin
            r_baud <= r_baud - 9'd1;
          end
        end
        default: r_bstate <= B_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pstate     <= P_OP;
      r_byte_cnt   <= '0;
      r_cmd_opcode <= '0;
      r_cmd_addr   <= '0;
      r_cmd_len    <= '0;
      r_cmd_valid  <= 1'b0;
      r_cmd_error  <= 1'b0;
    end else begin
      r_cmd_error <= 1'b0;
      case (r_pstate)
        P_OP: begin
          if (r_rx_byte_valid) begin
            if (r_rx_byte == OP_SETUP) begin
              r_cmd_opcode <= r_rx_byte;
              r_cmd_addr   <= '0;
              r_cmd_len    <= '0;
              r_byte_cnt   <= 2'd0;
              r_pstate     <= P_ADDR;
            end else begin
              r_cmd_error <= 1'b1;
            end
          end
        end
        P_ADDR: begin
          if (r_frame_error) begin
            r_cmd_opcode <= '0;
            r_cmd_addr   <= '0;
            r_pstate     <= P_OP;
          end else if (r_rx_byte_valid) begin
            r_cmd_addr <= {r_cmd_addr[23:0], r_rx_byte};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_pstate <= P_LEN;
            end
          end
        end
        P_LEN: begin
          if (r_frame_error) begin
            r_cmd_opcode <= '0;
            r_cmd_addr   <= '0;
            r_cmd_len    <= '0;
            r_pstate     <= P_OP;
          end else if (r_rx_byte_valid) begin
            r_cmd_len  <= {r_cmd_len[23:0], r_rx_byte};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_cmd_valid <= 1'b1;
              r_pstate    <= P_HOLD;
            end
          end
        end
        P_HOLD: begin
          // Bytes arriving while a command is held are overruns and dropped.
          if (r_rx_byte_valid) begin
            r_cmd_error <= 1'b1;
          end
          if (r_cmd_valid && cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_pstate    <= P_OP;
          end
        end
        default: r_pstate <= P_OP;
      endcase
    end
  end

  assign cmd_valid     = r_cmd_valid;
  assign cmd_opcode    = r_cmd_opcode;
  assign cmd_addr      = r_cmd_addr;
  assign cmd_len       = r_cmd_len;
  assign rx_byte       = r_rx_byte;
  assign rx_byte_valid = r_rx_byte_valid;
  assign frame_error   = r_frame_error;
  assign cmd_error     = r_cmd_error;
  assign busy          = (r_pstate != P_OP) || r_cmd_valid;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: byte and command scoreboards fed at stimulus
// time, drained by negedge monitors; short bit period keeps the run small.
module tb_uart_cmd_rx;

  localparam int BIT = 32;

  logic        clk;
  logic        reset;
  logic        uart_rxd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_len;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic        frame_error;
  logic        cmd_error;
  logic        busy;

  uart_cmd_rx #(.CLK_PER_BIT(BIT), .OP_SETUP(8'h30)) dut (
    .clk(clk), .reset(reset), .uart_rxd(uart_rxd),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .frame_error(frame_error), .cmd_error(cmd_error), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_rxv = 0;
  int n_cmd_err = 0;
  int n_frm_err = 0;
  int n_acc = 0;
  int n_vcyc = 0;

  logic [7:0]  exp_bytes[$];
  logic [7:0]  exp_op[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_len[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_byte_valid) begin
        n_rxv++;
        check("rx_byte_expected", 32'(exp_bytes.size() != 0), 32'd1);
        if (exp_bytes.size() != 0) check("rx_byte", 32'(rx_byte), 32'(exp_bytes.pop_front()));
      end
      if (cmd_error) n_cmd_err++;
      if (frame_error) n_frm_err++;
      if (cmd_valid) n_vcyc++;
      if (cmd_valid && cmd_ready) begin
        n_acc++;
        check("cmd_expected", 32'(exp_op.size() != 0), 32'd1);
        if (exp_op.size() != 0) begin
          check("cmd_opcode", 32'(cmd_opcode), 32'(exp_op.pop_front()));
          check("cmd_addr", cmd_addr, exp_addr.pop_front());
          check("cmd_len", cmd_len, exp_len.pop_front());
        end
      end
    end
  end

  task automatic send_raw(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    uart_rxd = stop_bit;
    repeat (BIT) @(negedge clk);
    uart_rxd = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    exp_bytes.push_back(b);
    send_raw(b, 1'b1);
  endtask

  task automatic send_setup(input logic [31:0] a, input logic [31:0] l);
    exp_op.push_back(8'h30);
    exp_addr.push_back(a);
    exp_len.push_back(l);
    send_good(8'h30);
    for (int i = 3; i >= 0; i--) send_good(a[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) send_good(l[i*8 +: 8]);
  endtask

  task automatic wait_acc(input string tag, input int target);
    for (int i = 0; i < 4 * BIT && n_acc < target; i++) @(negedge clk);
    check(tag, 32'(n_acc), 32'(target));
  endtask

  int r0, e0, f0, v0, a0;

  initial begin
    reset = 1'b1;
    uart_rxd = 1'b1;
    cmd_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_opcode", 32'(cmd_opcode), 32'd0);
    check("rst_addr", cmd_addr, 32'd0);
    check("rst_len", cmd_len, 32'd0);
    check("rst_rx_byte", 32'(rx_byte), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulses", 32'({rx_byte_valid, frame_error, cmd_error}), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // SETUP frame with ready held high
    e0 = n_cmd_err; f0 = n_frm_err; v0 = n_vcyc;
    send_setup(32'h02020202, 32'h00000004);
    wait_acc("t1_accept", 1);
    repeat (4) @(negedge clk);
    check("t1_valid_cycles", 32'(n_vcyc - v0), 32'd1);
    check("t1_cmd_err", 32'(n_cmd_err - e0), 32'd0);
    check("t1_frame_err", 32'(n_frm_err - f0), 32'd0);

    // MSB-first ordering, 9 byte pulses
    r0 = n_rxv;
    send_setup(32'h12345678, 32'h9ABCDEF0);
    wait_acc("t2_accept", 2);
    check("t2_rx_pulses", 32'(n_rxv - r0), 32'd9);

    // Backpressure and overrun
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    send_setup(32'hCAFE0001, 32'h00000100);
    repeat (4) @(negedge clk);
    check("t3_valid_held", 32'(cmd_valid), 32'd1);
    e0 = n_cmd_err;
    send_good(8'h55);
    repeat (4) @(negedge clk);
    check("t3_overrun_err", 32'(n_cmd_err - e0), 32'd1);
    check("t3_valid_after", 32'(cmd_valid), 32'd1);
    check("t3_opcode_held", 32'(cmd_opcode), 32'h30);
    check("t3_addr_held", cmd_addr, 32'hCAFE0001);
    check("t3_len_held", cmd_len, 32'h00000100);
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_no_accept", 32'(n_acc), 32'd2);
    @(posedge clk); #1;
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    check("t3_valid_drop", 32'(cmd_valid), 32'd0);
    check("t3_busy_drop", 32'(busy), 32'd0);
    wait_acc("t3_accept", 3);

    // Bad stop bit on address byte 2
    f0 = n_frm_err;
    send_good(8'h30);
    send_good(8'h11);
    send_raw(8'h22, 1'b0);
    repeat (BIT) @(negedge clk);
    check("t4_frame_err", 32'(n_frm_err - f0), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    send_setup(32'hA0B0C0D0, 32'h00000123);
    wait_acc("t4_accept", 4);

    // Glitch, then unknown opcode
    r0 = n_rxv; f0 = n_frm_err;
    uart_rxd = 1'b0;
    repeat (10) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check("t5_glitch_rx", 32'(n_rxv - r0), 32'd0);
    check("t5_glitch_frm", 32'(n_frm_err - f0), 32'd0);
    e0 = n_cmd_err; v0 = n_vcyc;
    send_good(8'hA5);
    repeat (4) @(negedge clk);
    check("t5_rx_byte", 32'(rx_byte), 32'hA5);
    check("t5_cmd_err", 32'(n_cmd_err - e0), 32'd1);
    check("t5_no_valid", 32'(n_vcyc - v0), 32'd0);

    // Reset mid-frame
    send_good(8'h30);
    send_good(8'h01);
    send_good(8'h02);
    send_good(8'h03);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t6_busy_rst", 32'(busy), 32'd0);
    check("t6_addr_rst", cmd_addr, 32'd0);
    a0 = n_acc;
    repeat (4) @(negedge clk);
    send_setup(32'h00000010, 32'h00000020);
    wait_acc("t6_accept", a0 + 1);

    repeat (8) @(negedge clk);
    check("end_bytes_drained", 32'(exp_bytes.size()), 32'd0);
    check("end_cmds_drained", 32'(exp_op.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
